mem_access_stage: RTL

MEM-stage data-memory access controller for the 5-stage pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its ALU result, store data, byte-op and control fields. Performs loads and stores over a request/grant/response data-memory bus, and stalls the pipeline until each access completes. Presents the formatted load result to the MEM/WB register.

---
 rtl/mem_access_stage_if.sv | 24 ++
 rtl/mem_access_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM-stage access controller (master) and the
// data memory (slave): request/grant handshake plus read response.
interface mem_access_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [3:0]            mem_be_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access controller. Takes the EX/MEM fields, runs one
// load or store over the request/grant/response bus, stalls the pipeline
// until the access finishes and presents formatted load data to MEM/WB.
module mem_access_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] alu_result_m_i,
  input  logic [DATA_WIDTH-1:0] write_data_m_i,
  input  logic [1:0]            result_src_m_i,
  input  logic                  mem_write_m_i,
  input  logic                  byte_op_m_i,
  mem_access_stage_if.master    bus,
  output logic [DATA_WIDTH-1:0] read_data_m_o,
  output logic                  stall_o,
  output logic                  misaligned_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic       access_s;
  logic       misaligned_s;
  logic       start_s;
  logic       byte_store_s;
  logic       req_byte_r;
  logic [1:0] req_lane_r;

  // Pick one byte lane out of a response word.
  function automatic logic [7:0] lane_byte(input logic [DATA_WIDTH-1:0] word,
                                           input logic [1:0] lane);
    case (lane)
      2'b00:   lane_byte = word[7:0];
      2'b01:   lane_byte = word[15:8];
      2'b10:   lane_byte = word[23:16];
      2'b11:   lane_byte = word[31:24];
      default: lane_byte = word[7:0];
    endcase
  endfunction

  // Decode the instruction sitting in EX/MEM; a set store bit wins over a load select.
  always_comb begin
    access_s     = mem_write_m_i | (result_src_m_i == 2'b01);
    misaligned_s = access_s & ~byte_op_m_i & (alu_result_m_i[1:0] != 2'b00);
    start_s      = (state_r == S_IDLE) & access_s & ~misaligned_s;
    byte_store_s = mem_write_m_i & byte_op_m_i;
    misaligned_o = misaligned_s;
  end

  // Next-state and stall decode; only DONE and an idle non-access release the pipeline.
  always_comb begin
    state_next_s = state_r;
    stall_o      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start_s) begin
          state_next_s = S_REQ;
          stall_o      = 1'b1;
        end else begin
          state_next_s = S_IDLE;
          stall_o      = 1'b0;
        end
      end
      S_REQ: begin
        stall_o = 1'b1;
        if (bus.mem_gnt_i) begin
          state_next_s = bus.mem_we_o ? S_DONE : S_WAIT;
        end else begin
          state_next_s = S_REQ;
        end
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (bus.mem_rvalid_i) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_DONE: begin
        stall_o      = 1'b0;
        state_next_s = S_IDLE;
      end
      default: begin
        stall_o      = 1'b0;
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request registers: bus fields are latched once in IDLE so they stay stable while requesting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_req_o   <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= {DATA_WIDTH{1'b0}};
      bus.mem_wdata_o <= {DATA_WIDTH{1'b0}};
      bus.mem_be_o    <= 4'b0000;
      req_byte_r      <= 1'b0;
      req_lane_r      <= 2'b00;
    end else begin
      bus.mem_req_o <= (state_next_s == S_REQ);
      if (start_s) begin
        bus.mem_we_o   <= mem_write_m_i;
        bus.mem_addr_o <= {alu_result_m_i[DATA_WIDTH-1:2], 2'b00};
        if (byte_store_s) begin
          bus.mem_wdata_o <= {(DATA_WIDTH/8){write_data_m_i[7:0]}};
          bus.mem_be_o    <= 4'b0001 << alu_result_m_i[1:0];
        end else begin
          bus.mem_wdata_o <= write_data_m_i;
          bus.mem_be_o    <= 4'b1111;
        end
        req_byte_r <= byte_op_m_i;
        req_lane_r <= alu_result_m_i[1:0];
      end
    end
  end

  // Load result: captured only from a response seen in WAIT, otherwise held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data_m_o <= {DATA_WIDTH{1'b0}};
    end else if ((state_r == S_WAIT) && bus.mem_rvalid_i) begin
      if (req_byte_r) begin
        read_data_m_o <= {{(DATA_WIDTH-8){1'b0}}, lane_byte(bus.mem_rdata_i, req_lane_r)};
      end else begin
        read_data_m_o <= bus.mem_rdata_i;
      end
    end else begin
      read_data_m_o <= read_data_m_o;
    end
  end

endmodule
